// File: rtl/row_sched.sv
// row_sched: buffers 4-column rows in a small FIFO and streams them to a systolic array as skewed column feeds.
// Define ROW_SCHED_PERF_EN to add the bubble_cnt stall counter port.
module row_sched #(
  parameter int ROWS = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_row,
  output logic [31:0]  x01,
  output logic [31:0]  x02,
  output logic [31:0]  x03,
  output logic [31:0]  x04,
  output logic         op_11,
  output logic         op_12,
  output logic         op_13,
  output logic         op_14,
  output logic         op_22,
  output logic         op_23,
  output logic         op_24,
  output logic         busy,
  output logic         done
`ifdef ROW_SCHED_PERF_EN
  ,
  output logic [15:0]  bubble_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_nxt;
  logic [7:0] row_cnt, row_cnt_nxt;
  logic [2:0] drain_cnt, drain_cnt_nxt;
  logic [127:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [127:0] row;
  logic push, pop;
  logic [95:0] d2;
  logic [63:0] d3;
  logic [31:0] d4;
  assign in_ready = count != CW'(FIFO_DEPTH);
  assign push = in_valid && in_ready;
  assign pop = state == STREAM && count != '0;
  assign row = mem[rd_ptr];
  always_comb begin
    state_nxt = state;
    row_cnt_nxt = row_cnt;
    drain_cnt_nxt = drain_cnt;
    unique case (state)
      IDLE: begin
        state_nxt = start ? STREAM : IDLE;
        row_cnt_nxt = start ? 8'd0 : row_cnt;
      end
      STREAM: begin
        row_cnt_nxt = pop ? row_cnt + 8'd1 : row_cnt;
        state_nxt = pop && row_cnt == 8'(ROWS - 1) ? DRAIN : STREAM;
        drain_cnt_nxt = 3'd0;
      end
      DRAIN: begin
        drain_cnt_nxt = drain_cnt + 3'd1;
        state_nxt = drain_cnt == 3'd5 ? IDLE : DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // done lands in the last DRAIN cycle, six cycles after the final pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      row_cnt <= '0;
      drain_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      row_cnt <= row_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      busy <= state_nxt != IDLE;
      done <= state == DRAIN && drain_cnt == 3'd4;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_row;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // each stage hands the remaining columns one step down the skew
  always_ff @(posedge clk) begin
    if (!rst) begin
      {x01, x02, x03, x04, d2, d3, d4} <= '0;
      {op_11, op_12, op_13, op_14, op_22, op_23, op_24} <= '0;
    end else begin
      x01 <= pop ? row[31:0] : '0;
      d2 <= pop ? row[127:32] : '0;
      x02 <= d2[31:0];
      d3 <= d2[95:32];
      x03 <= d3[31:0];
      d4 <= d3[63:32];
      x04 <= d4;
      op_11 <= pop;
      op_12 <= op_11;
      op_13 <= op_12;
      op_22 <= op_12;
      op_14 <= op_13;
      op_23 <= op_13;
      op_24 <= op_14;
    end
  end
`ifdef ROW_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) bubble_cnt <= '0;
    else if (state == IDLE && start) bubble_cnt <= '0;
    else if (state == STREAM && count == '0 && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/row_sched.md
ROW_SCHED -- requirements
Module: row_sched

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning rows per matrix (legal range 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the row-buffer depth (power of 2, at least 2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a matrix of ROWS rows.
REQ-006 SHALL have port in_valid  input  1  in_row holds a valid row.
REQ-007 SHALL have port in_ready  output  1  row buffer can accept a row.
REQ-008 SHALL have port in_row  input  128  row words: [31:0] column 1 through [127:96] column 4.
REQ-009 SHALL have ports x01, x02, x03, x04  output  32 each  skewed column feeds to the array.
REQ-010 SHALL have ports op_11, op_12, op_13, op_14, op_22, op_23, op_24  output  1 each  per-PE operation enables.
REQ-011 SHALL have port busy  output  1  a matrix is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the matrix has fully drained.

Function
REQ-013 SHALL buffer rows in a FIFO_DEPTH-entry FIFO; a push occurs when in_valid and in_ready are both high.
REQ-014 SHALL drive in_ready = FIFO not full, in every state; a full FIFO SHALL NOT accept a push even when a pop occurs in the same cycle.
REQ-015 SHALL treat a simultaneous push and pop on a non-full FIFO as leaving the occupancy unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 SHALL implement the FSM IDLE -> STREAM -> DRAIN -> IDLE.
- IDLE: on start, go to STREAM with row_cnt = 0.
- STREAM: pop one row per cycle while the FIFO is non-empty; row_cnt increments on each pop; the pop that brings row_cnt to ROWS goes to DRAIN.
- DRAIN: count 5 cycles, then return to IDLE.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL NOT pop in IDLE or DRAIN; rows pushed there remain buffered for the next matrix.
REQ-019 SHALL, for a row popped in cycle t, present and enable it on this skewed schedule:
- t+1: x01 = col1, op_11 = 1
- t+2: x02 = col2, op_12 = 1
- t+3: x03 = col3, op_13 = 1, op_22 = 1
- t+4: x04 = col4, op_14 = 1, op_23 = 1
- t+5: op_24 = 1
REQ-020 SHALL, in STREAM with an empty FIFO, insert a bubble: the corresponding x outputs are 0 and the op enables are 0 at each skewed stage.
REQ-021 SHALL pulse done for exactly one cycle at t_last+6, where t_last is the cycle of the final pop, and SHALL return to IDLE in that same cycle.
REQ-022 SHALL drive busy high in STREAM and DRAIN only.
REQ-023 SHALL produce all outputs from registers, except in_ready, which is derived from the registered FIFO occupancy.

Reset
REQ-024 SHALL, on rst = 0 at a clock edge, clear the FSM to IDLE and clear row_cnt, the FIFO pointers and occupancy, and all skew stages.
REQ-025 SHALL reset values: x01..x04 = 0, all op_* = 0, busy = 0, done = 0, in_ready = 1 (the cycle after reset).
REQ-026 SHALL, on reset mid-matrix, discard buffered rows and in-flight wavefronts, with no done pulse.

Configuration
REQ-027 SHALL, with ROW_SCHED_PERF_EN defined, add output bubble_cnt (16 bits): cleared on reset and on start acceptance, incremented on each STREAM cycle with an empty FIFO, saturating at 0xFFFF.
REQ-028 SHALL, without ROW_SCHED_PERF_EN, omit the bubble_cnt port and its logic entirely.

Verification
REQ-029 SHALL cover: ROWS=8 with 8 rows preloaded, then start -> op_11 high for 8 consecutive cycles; op_24 trails op_11 by 4 cycles; done at final pop +6; busy for 14 cycles.
REQ-030 SHALL cover: row {4,3,2,1} (col1 = 1) popped at cycle t -> x01 = 1 @t+1, x02 = 2 @t+2, x03 = 3 @t+3, x04 = 4 @t+4.
REQ-031 SHALL cover: 5 pushes with in_valid held and no start -> in_ready low after 4 pushes; the 5th row is accepted only after the first pop.
REQ-032 SHALL cover: in_valid stalls for 3 cycles mid-matrix -> 3-cycle bubble (op_* = 0, x = 0) at each stage; bubble_cnt = 3 when ROW_SCHED_PERF_EN is defined.
REQ-033 SHALL cover: rst low during STREAM, then start with 8 new rows -> all outputs 0 during reset, no done pulse; the new matrix completes normally.
REQ-034 SHALL cover: start pulsed during DRAIN -> ignored, exactly one done pulse, FSM back in IDLE.
